water: RTL and testbench

//  Irrigation controller for the smart-home automation design.
//  - Reads a soil-moisture byte and a 2-bit tank level.
//  - Drives a Sprinkler (watering) and a Pump (tank refill) with hysteresis.
//  - Dry-run protection and a pump-timeout fault latch.
//  - Outputs are registered on CLK.

---
 rtl/water.sv | 116 +++++++++++
 tb/tb_water.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/water.sv
// Irrigation controller: sprinkler valve and tank refill pump, each with level hysteresis,
// plus dry-run protection and a sticky pump-timeout fault.
module water #(
  parameter logic [7:0]  MOIST_LOW     = 8'd80,
  parameter logic [7:0]  MOIST_HIGH    = 8'd120,
  parameter int unsigned MIN_ON_CYCLES = 0,
  parameter int unsigned PUMP_TIMEOUT  = 1000
) (
  input  logic [7:0] Moisture_sensor,
  input  logic [1:0] Water_sensor,
  input  logic       CLK,
  output logic       Pump,
  output logic       Sprinkler,
  input  logic       Reset
);

  // state | meaning
  // SPR_OFF    | sprinkler valve closed
  // SPR_ON     | sprinkler valve open, hold counter running
  // PUMP_IDLE  | pump off, tank level adequate
  // PUMP_FILL  | pump refilling, run counter running
  // PUMP_FAULT | pump ran too long; off until reset

  localparam int HOLD_W = (MIN_ON_CYCLES > 0) ? $clog2(MIN_ON_CYCLES + 1) : 1;
  localparam int RUN_W  = (PUMP_TIMEOUT > 0)  ? $clog2(PUMP_TIMEOUT + 1)  : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_ON_CYCLES);
  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(PUMP_TIMEOUT);

  typedef enum logic {SPR_OFF, SPR_ON} spr_state_t;
  typedef enum logic [1:0] {PUMP_IDLE, PUMP_FILL, PUMP_FAULT} pump_state_t;

  spr_state_t        spr_state, spr_next;
  pump_state_t       pump_state, pump_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic [RUN_W-1:0]  run_cnt, run_next;

  logic tank_empty, tank_full, tank_low, soil_dry, soil_wet;
  logic hold_done, run_sat, timeout_hit;

  assign tank_empty = (Water_sensor == 2'b00);
  assign tank_full  = (Water_sensor == 2'b11);
  assign tank_low   = ~Water_sensor[1];
  assign soil_dry   = (Moisture_sensor < MOIST_LOW);
  assign soil_wet   = (Moisture_sensor >= MOIST_HIGH);

  // Hold counter saturates at MIN_ON_CYCLES, so equality means the minimum on-time has elapsed.
  assign hold_done   = (hold_cnt == HOLD_MAX);
  assign run_sat     = (PUMP_TIMEOUT == 0) || (run_cnt == RUN_MAX);
  assign timeout_hit = (PUMP_TIMEOUT != 0) && (run_cnt == RUN_MAX - 1'b1);

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      spr_state  <= SPR_OFF;
      pump_state <= PUMP_IDLE;
      hold_cnt   <= '0;
      run_cnt    <= '0;
    end else begin
      spr_state  <= spr_next;
      pump_state <= pump_next;
      hold_cnt   <= hold_next;
      run_cnt    <= run_next;
    end
  end

  always_comb begin
    spr_next  = spr_state;
    hold_next = hold_cnt;
    case (spr_state)
      SPR_OFF: begin
        if (soil_dry && !tank_empty) begin
          spr_next  = SPR_ON;
          hold_next = '0;
        end
      end
      SPR_ON: begin
        // Dry-run protection overrides the minimum on-time.
        if (tank_empty) begin
          spr_next = SPR_OFF;
        end else if (soil_wet && hold_done) begin
          spr_next = SPR_OFF;
        end else if (!hold_done) begin
          hold_next = hold_cnt + 1'b1;
        end
      end
      default: spr_next = SPR_OFF;
    endcase
  end

  always_comb begin
    pump_next = pump_state;
    run_next  = run_cnt;
    case (pump_state)
      PUMP_IDLE: begin
        if (tank_low) begin
          pump_next = PUMP_FILL;
          run_next  = '0;
        end
      end
      PUMP_FILL: begin
        // A full tank stops the pump even on the cycle the timeout would expire.
        if (tank_full) begin
          pump_next = PUMP_IDLE;
        end else begin
          if (!run_sat) run_next = run_cnt + 1'b1;
          if (timeout_hit) pump_next = PUMP_FAULT;
        end
      end
      PUMP_FAULT: pump_next = PUMP_FAULT;
      default:    pump_next = PUMP_IDLE;
    endcase
  end

  assign Sprinkler = (spr_state == SPR_ON);
  assign Pump      = (pump_state == PUMP_FILL);

endmodule

// File: tb/tb_water.sv
// Scoreboard bench for water: a cycle-level reference model predicts outputs per edge,
// a monitor compares them against the DUT one step after each rising edge.
module tb_water;

  localparam int MIN_ON  = 3;
  localparam int TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] moist = 8'd0;
  logic [1:0] water = 2'b00;
  logic       pump, spr;

  water #(
    .MOIST_LOW(8'd80), .MOIST_HIGH(8'd120),
    .MIN_ON_CYCLES(MIN_ON), .PUMP_TIMEOUT(TIMEOUT)
  ) dut (
    .Moisture_sensor(moist),
    .Water_sensor(water),
    .CLK(clk),
    .Pump(pump),
    .Sprinkler(spr),
    .Reset(rst_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic  pump;
    logic  spr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 0;

  // Reference model: plain integers, one call per clock edge.
  bit m_spr_on = 0;
  int m_on_time = 0;
  bit m_filling = 0;
  bit m_faulted = 0;
  int m_fill_time = 0;

  task automatic model_step(input logic r, input int m, input int w);
    if (!r) begin
      m_spr_on = 0; m_on_time = 0;
      m_filling = 0; m_faulted = 0; m_fill_time = 0;
      return;
    end
    if (!m_spr_on) begin
      if (m < 80 && w != 0) begin
        m_spr_on = 1;
        m_on_time = 0;
      end
    end else if (w == 0) begin
      m_spr_on = 0;
    end else if (m >= 120 && m_on_time >= MIN_ON) begin
      m_spr_on = 0;
    end else if (m_on_time < MIN_ON) begin
      m_on_time++;
    end
    if (!m_faulted) begin
      if (!m_filling) begin
        if (w <= 1) begin
          m_filling = 1;
          m_fill_time = 1;
        end
      end else if (w == 3) begin
        m_filling = 0;
      end else if (m_fill_time >= TIMEOUT) begin
        m_filling = 0;
        m_faulted = 1;
      end else begin
        m_fill_time++;
      end
    end
  endtask

  task automatic apply(input logic r, input int m, input int w, input string nm);
    exp_t e;
    @(negedge clk);
    rst_n = r;
    moist = 8'(m);
    water = 2'(w);
    model_step(r, m, w);
    e.name = nm;
    e.pump = m_filling;
    e.spr  = m_spr_on;
    sb.push_back(e);
  endtask

  task automatic hold(input int n, input int m, input int w, input string nm);
    for (int i = 0; i < n; i++) apply(1'b1, m, w, nm);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (pump !== e.pump) begin
          errors++;
          $display("FAIL %s pump: got %b expected %b (m=%0d w=%0d)", e.name, pump, e.pump, moist, water);
        end
        checks++;
        if (spr !== e.spr) begin
          errors++;
          $display("FAIL %s sprinkler: got %b expected %b (m=%0d w=%0d)", e.name, spr, e.spr, moist, water);
        end
      end
    end
  end

  function automatic int pick_moist();
    case ($urandom_range(0, 9))
      0: return 0;
      1: return 255;
      2: return 79;
      3: return 80;
      4: return 119;
      5: return 120;
      6: return $urandom_range(60, 140);
      default: return $urandom_range(0, 255);
    endcase
  endfunction

  initial begin : stim
    int wt;
    apply(1'b0, 32, 2, "reset");
    hold(1, 32, 2, "dry_medium");
    hold(5, 160, 2, "wet_medium_minon");
    hold(2, 32, 1, "dry_low");
    hold(5, 160, 3, "wet_full");
    hold(2, 80, 3, "moist80_off");
    hold(1, 32, 3, "dry_full");
    hold(3, 100, 3, "band_hold");
    hold(1, 100, 0, "dry_run");
    apply(1'b0, 100, 2, "reset_mid");
    hold(12, 100, 1, "timeout");
    hold(3, 30, 0, "fault_empty");
    hold(2, 200, 3, "fault_full");
    apply(1'b0, 0, 3, "reset_fault");
    hold(2, 0, 3, "moist0");
    hold(4, 255, 3, "moist255");
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        apply(1'b0, pick_moist(), $urandom_range(0, 3), "rand_reset");
      end else begin
        wt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : int'(water);
        hold($urandom_range(1, 4), pick_moist(), wt, "random");
      end
    end
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
